// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and constants for the unified memory arbiter.
package mem_arb_pkg;

    // Legal range of the memory read latency and the width of the latency counter.
    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 15;
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DM_BUSY = 2'd1,
        IF_BUSY = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } arb_gnt_t;

    // A requester wants the memory when it asks and has no result parked yet.
    function automatic logic is_pending(input logic req, input logic done);
        return req & ~done;
    endfunction

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Requester and memory-port signals shared between the pipeline and the arbiter.
interface mem_arb_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic [DATA_W-1:0] if_rdata;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_ready;
    logic [DATA_W-1:0] dm_rdata;
    logic              advance;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    // Arbiter side.
    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, advance, mem_rdata,
        output if_ready, if_rdata, dm_ready, dm_rdata, mem_en, mem_we, mem_addr,
               mem_wdata, busy
    );

    // Pipeline and memory side.
    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, advance, mem_rdata,
        input  if_ready, if_rdata, dm_ready, dm_rdata, mem_en, mem_we, mem_addr,
               mem_wdata, busy
    );

endinterface

// File: rtl/unified_mem_arbiter_mem_lat_counter.sv
// Loadable up-counter that flags when the memory read data is due.
module mem_lat_counter
    import mem_arb_pkg::*;
#(
    parameter int LAT = 2
)(
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic tc
);
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(LAT);

    logic [CNT_W-1:0] cnt_r;

    // Restart at zero on a new issue, otherwise count the cycles of the access.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (en) begin
            cnt_r <= cnt_r + 4'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tc = (cnt_r == TC_VAL);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and data access.
// Data side has fixed priority; each result is parked until the pipeline advances.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
)(
    input  logic     clk,
    input  logic     rst,
    mem_arb_if.slave bus
);
    arb_state_t        state_r, next_state_s;
    arb_gnt_t          gnt_s;
    logic              issue_s, rearb_s, tc_s, complete_s;
    logic              if_pend_s, dm_pend_s, cap_if_s, cap_dm_s;
    logic              if_done_r, dm_done_r, if_done_nx_s, dm_done_nx_s, discard_r;
    logic              mem_en_r, mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r, if_rdata_r, dm_rdata_r;

    mem_lat_counter #(.LAT(MEM_LAT)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (issue_s),
        .en   (state_r != IDLE),
        .tc   (tc_s)
    );

    assign complete_s = (state_r != IDLE) && tc_s;

    // Next state, done-flag updates, capture strobes and grant selection.
    always_comb begin
        next_state_s = state_r;
        gnt_s        = GNT_IF;
        issue_s      = 1'b0;
        rearb_s      = 1'b0;
        if_pend_s    = 1'b0;
        dm_pend_s    = 1'b0;
        cap_if_s     = 1'b0;
        cap_dm_s     = 1'b0;
        if_done_nx_s = if_done_r;
        dm_done_nx_s = dm_done_r;
        if (bus.advance) begin
            if_done_nx_s = 1'b0;
            dm_done_nx_s = 1'b0;
        end else begin
            if_done_nx_s = if_done_r;
            dm_done_nx_s = dm_done_r;
        end
        case (state_r)
            IDLE: begin
                rearb_s   = 1'b1;
                if_pend_s = is_pending(bus.if_req, if_done_r);
                dm_pend_s = is_pending(bus.dm_req, dm_done_r);
            end
            DM_BUSY: begin
                if (complete_s) begin
                    // A store completes without touching the load data register.
                    dm_done_nx_s = 1'b1;
                    cap_dm_s     = ~mem_we_r;
                    rearb_s      = 1'b1;
                    if_pend_s    = is_pending(bus.if_req, if_done_nx_s);
                    dm_pend_s    = is_pending(bus.dm_req, dm_done_nx_s);
                end else begin
                    rearb_s = 1'b0;
                end
            end
            IF_BUSY: begin
                if (complete_s) begin
                    // A fetch flushed mid-flight is dropped and re-requested.
                    if (!discard_r) begin
                        if_done_nx_s = 1'b1;
                        cap_if_s     = 1'b1;
                    end else begin
                        cap_if_s = 1'b0;
                    end
                    rearb_s   = 1'b1;
                    if_pend_s = is_pending(bus.if_req, if_done_nx_s);
                    dm_pend_s = is_pending(bus.dm_req, dm_done_nx_s);
                end else begin
                    rearb_s = 1'b0;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
        if (rearb_s) begin
            if (dm_pend_s) begin
                next_state_s = DM_BUSY;
                gnt_s        = GNT_DM;
                issue_s      = 1'b1;
            end else if (if_pend_s) begin
                next_state_s = IF_BUSY;
                gnt_s        = GNT_IF;
                issue_s      = 1'b1;
            end else begin
                next_state_s = IDLE;
            end
        end else begin
            gnt_s = GNT_IF;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Done flags and the flush marker for an in-flight fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_done_r <= 1'b0;
            dm_done_r <= 1'b0;
            discard_r <= 1'b0;
        end else begin
            if_done_r <= if_done_nx_s;
            dm_done_r <= dm_done_nx_s;
            if (issue_s || complete_s) begin
                discard_r <= 1'b0;
            end else if ((state_r == IF_BUSY) && bus.advance) begin
                discard_r <= 1'b1;
            end else begin
                discard_r <= discard_r;
            end
        end
    end

    // Memory port: strobe for one cycle on issue, address/data/we hold in between.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
        end else begin
            mem_en_r <= issue_s;
            if (issue_s && (gnt_s == GNT_DM)) begin
                mem_we_r    <= bus.dm_we;
                mem_addr_r  <= bus.dm_addr;
                mem_wdata_r <= bus.dm_wdata;
            end else if (issue_s) begin
                mem_we_r    <= 1'b0;
                mem_addr_r  <= bus.if_addr;
                mem_wdata_r <= mem_wdata_r;
            end else begin
                mem_we_r    <= mem_we_r;
                mem_addr_r  <= mem_addr_r;
                mem_wdata_r <= mem_wdata_r;
            end
        end
    end

    // Result registers: capture read data on completion and hold it afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_rdata_r <= {DATA_W{1'b0}};
            dm_rdata_r <= {DATA_W{1'b0}};
        end else begin
            if (cap_if_s) begin
                if_rdata_r <= bus.mem_rdata;
            end else begin
                if_rdata_r <= if_rdata_r;
            end
            if (cap_dm_s) begin
                dm_rdata_r <= bus.mem_rdata;
            end else begin
                dm_rdata_r <= dm_rdata_r;
            end
        end
    end

    assign bus.mem_en    = mem_en_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.if_rdata  = if_rdata_r;
    assign bus.dm_rdata  = dm_rdata_r;
    assign bus.if_ready  = if_done_r & bus.if_req;
    assign bus.dm_ready  = dm_done_r & bus.dm_req;
    assign bus.busy      = (state_r != IDLE);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter (MEM_LAT=2 main instance, MEM_LAT=3 for reset).
module tb_unified_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int LAT  = 2;
    localparam int LAT3 = 3;

    logic clk = 1'b0;
    logic rst;
    logic rst3;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   c0;

    always #5 clk = ~clk;

    mem_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    mem_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();

    unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
        .clk (clk), .rst (rst), .bus (bus)
    );
    unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT3)) dut3 (
        .clk (clk), .rst (rst3), .bus (bus3)
    );

    typedef struct {
        logic        is_dm;
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    // Memory contents used by the tests; everything else is a function of the address.
    function automatic logic [31:0] mem_init(input logic [31:0] a);
        case (a)
            32'h0000_0004: return 32'h2002_0005;
            32'h0000_0008: return 32'h1122_3344;
            32'h0000_0010: return 32'hAAAA_0010;
            32'h0000_0020: return 32'hCAFE_0020;
            32'h0000_0030: return 32'hBBBB_0030;
            32'h0000_0040: return 32'h0000_ABCD;
            default:       return a ^ 32'h5A5A_0000;
        endcase
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Fixed-latency memory models with a store recorder on the main port.
    logic [31:0] pipe  [LAT];
    logic [31:0] pipe3 [LAT3];
    logic [31:0] st_addr = 32'h0;
    logic [31:0] st_data = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    // Main memory model.
    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) begin
            st_addr <= bus.mem_addr;
            st_data <= bus.mem_wdata;
        end
        pipe[0] <= bus.mem_en ? mem_init(bus.mem_addr) : 32'hDEAD_0BAD;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.mem_rdata = pipe[LAT-1];

    // Memory model for the MEM_LAT=3 instance.
    always @(posedge clk) begin
        pipe3[0] <= bus3.mem_en ? mem_init(bus3.mem_addr) : 32'hDEAD_0BAD;
        for (int i = 1; i < LAT3; i++) pipe3[i] <= pipe3[i-1];
    end
    assign bus3.mem_rdata = pipe3[LAT3-1];

    // Advance must never arrive while a data access is outstanding.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(bus.advance && (dut.state_r == DM_BUSY)))
                else $error("protocol: advance while DM_BUSY");
        end
    end

    // Scoreboard: every rising ready pops one expected result.
    logic if_prev = 1'b0;
    logic dm_prev = 1'b0;

    task automatic pop_check(input logic is_dm);
        exp_t e;
        if (exp_q.size() == 0) begin
            check_val("sb_unexpected_ready", 32'(is_dm) + 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_val("sb_kind", 32'(is_dm), 32'(e.is_dm));
            check_val("sb_data", is_dm ? bus.dm_rdata : bus.if_rdata, e.data);
            check_val("sb_cycle", 32'(cyc), 32'(e.cyc));
        end
    endtask

    always @(negedge clk) begin
        if (bus.dm_ready && !dm_prev) pop_check(1'b1);
        if (bus.if_ready && !if_prev) pop_check(1'b0);
        dm_prev <= bus.dm_ready;
        if_prev <= bus.if_ready;
    end

    task automatic wait_drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            step(1);
            n++;
        end
        check_val(tag, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic release_all();
        bus.advance = 1'b1;
        bus.if_req  = 1'b0;
        bus.dm_req  = 1'b0;
        bus.dm_we   = 1'b0;
        step(1);
        bus.advance = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rst3 = 1'b1;
        bus.if_req = 1'b1; bus.if_addr = 32'h0; bus.dm_req = 1'b1; bus.dm_we = 1'b0;
        bus.dm_addr = 32'h0; bus.dm_wdata = 32'h0; bus.advance = 1'b0;
        bus3.if_req = 1'b0; bus3.if_addr = 32'h0; bus3.dm_req = 1'b0; bus3.dm_we = 1'b0;
        bus3.dm_addr = 32'h0; bus3.dm_wdata = 32'h0; bus3.advance = 1'b0;
        step(3);
        // Reset values, requests held high so the ready gating is exercised.
        check_val("rst_busy", 32'(bus.busy), 32'd0);
        check_val("rst_mem_en", 32'(bus.mem_en), 32'd0);
        check_val("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check_val("rst_mem_addr", bus.mem_addr, 32'h0);
        check_val("rst_mem_wdata", bus.mem_wdata, 32'h0);
        check_val("rst_if_ready", 32'(bus.if_ready), 32'd0);
        check_val("rst_dm_ready", 32'(bus.dm_ready), 32'd0);
        check_val("rst_if_rdata", bus.if_rdata, 32'h0);
        check_val("rst_dm_rdata", bus.dm_rdata, 32'h0);
        bus.if_req = 1'b0; bus.dm_req = 1'b0;
        rst = 1'b0; rst3 = 1'b0;
        step(2);

        // Single fetch.
        c0 = cyc; bus.if_req = 1'b1; bus.if_addr = 32'h4;
        exp_q.push_back('{is_dm: 1'b0, data: 32'h2002_0005, cyc: c0 + 4});
        step(1);
        check_val("f1_mem_en", 32'(bus.mem_en), 32'd1);
        check_val("f1_mem_addr", bus.mem_addr, 32'h4);
        check_val("f1_mem_we", 32'(bus.mem_we), 32'd0);
        check_val("f1_busy", 32'(bus.busy), 32'd1);
        step(1);
        check_val("f1_mem_en_c2", 32'(bus.mem_en), 32'd0);
        step(1);
        check_val("f1_ready_c3", 32'(bus.if_ready), 32'd0);
        step(1);
        check_val("f1_ready_c4", 32'(bus.if_ready), 32'd1);
        check_val("f1_rdata_c4", bus.if_rdata, 32'h2002_0005);
        step(1);
        check_val("f1_ready_hold", 32'(bus.if_ready), 32'd1);
        check_val("f1_idle", 32'(bus.busy), 32'd0);
        check_val("f1_no_reissue", 32'(bus.mem_en), 32'd0);
        release_all();
        check_val("f1_ready_gone", 32'(bus.if_ready), 32'd0);
        check_val("f1_rdata_hold", bus.if_rdata, 32'h2002_0005);
        wait_drain("f1_drain");
        step(1);

        // Simultaneous load and fetch: data side first, fetch back-to-back.
        c0 = cyc;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h40;
        bus.if_req = 1'b1; bus.if_addr = 32'h8;
        exp_q.push_back('{is_dm: 1'b1, data: 32'h0000_ABCD, cyc: c0 + 4});
        exp_q.push_back('{is_dm: 1'b0, data: 32'h1122_3344, cyc: c0 + 7});
        step(1);
        check_val("s_dm_en", 32'(bus.mem_en), 32'd1);
        check_val("s_dm_addr", bus.mem_addr, 32'h40);
        step(3);
        check_val("s_if_en_c4", 32'(bus.mem_en), 32'd1);
        check_val("s_if_addr_c4", bus.mem_addr, 32'h8);
        check_val("s_dm_ready_c4", 32'(bus.dm_ready), 32'd1);
        check_val("s_if_ready_c4", 32'(bus.if_ready), 32'd0);
        wait_drain("s_drain");
        check_val("s_dm_ready_hold", 32'(bus.dm_ready), 32'd1);
        release_all();
        step(1);

        // Store: one write strobe, load data register untouched.
        c0 = cyc;
        bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h44; bus.dm_wdata = 32'hDEAD_BEEF;
        exp_q.push_back('{is_dm: 1'b1, data: 32'h0000_ABCD, cyc: c0 + 4});
        step(1);
        check_val("st_en", 32'(bus.mem_en), 32'd1);
        check_val("st_we", 32'(bus.mem_we), 32'd1);
        check_val("st_addr", bus.mem_addr, 32'h44);
        check_val("st_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        step(1);
        check_val("st_en_c2", 32'(bus.mem_en), 32'd0);
        check_val("st_addr_hold", bus.mem_addr, 32'h44);
        step(2);
        check_val("st_ready_c4", 32'(bus.dm_ready), 32'd1);
        check_val("st_mem_addr", st_addr, 32'h44);
        check_val("st_mem_data", st_data, 32'hDEAD_BEEF);
        wait_drain("st_drain");
        release_all();
        step(1);

        // Flush: advance during IF_BUSY with a new fetch address.
        c0 = cyc; bus.if_req = 1'b1; bus.if_addr = 32'h10;
        exp_q.push_back('{is_dm: 1'b0, data: 32'hBBBB_0030, cyc: c0 + 7});
        step(1);
        check_val("fl_addr1", bus.mem_addr, 32'h10);
        step(1);
        check_val("fl_busy", 32'(bus.busy), 32'd1);
        bus.advance = 1'b1; bus.if_addr = 32'h30;
        step(1);
        bus.advance = 1'b0;
        step(1);
        check_val("fl_reissue_en", 32'(bus.mem_en), 32'd1);
        check_val("fl_reissue_addr", bus.mem_addr, 32'h30);
        check_val("fl_no_ready", 32'(bus.if_ready), 32'd0);
        wait_drain("fl_drain");
        check_val("fl_rdata", bus.if_rdata, 32'hBBBB_0030);
        release_all();
        step(1);

        // Advance on the completion edge: completion wins.
        c0 = cyc; bus.if_req = 1'b1; bus.if_addr = 32'h20;
        exp_q.push_back('{is_dm: 1'b0, data: 32'hCAFE_0020, cyc: c0 + 4});
        step(3);
        bus.advance = 1'b1;
        step(1);
        bus.advance = 1'b0;
        check_val("co_ready_c4", 32'(bus.if_ready), 32'd1);
        step(1);
        check_val("co_ready_c5", 32'(bus.if_ready), 32'd1);
        check_val("co_rdata", bus.if_rdata, 32'hCAFE_0020);
        wait_drain("co_drain");
        release_all();
        step(1);

        // Reset during DM_BUSY on the MEM_LAT=3 instance.
        c0 = cyc; bus3.dm_req = 1'b1; bus3.dm_addr = 32'h40;
        step(1);
        check_val("r3_en", 32'(bus3.mem_en), 32'd1);
        step(1);
        check_val("r3_busy_pre", 32'(bus3.busy), 32'd1);
        rst3 = 1'b1;
        step(1);
        check_val("r3_busy", 32'(bus3.busy), 32'd0);
        check_val("r3_dm_ready", 32'(bus3.dm_ready), 32'd0);
        check_val("r3_if_ready", 32'(bus3.if_ready), 32'd0);
        check_val("r3_mem_en", 32'(bus3.mem_en), 32'd0);
        bus3.dm_req = 1'b0; rst3 = 1'b0;
        step(3);
        check_val("r3_no_capture", bus3.dm_rdata, 32'h0);
        check_val("r3_idle", 32'(bus3.busy), 32'd0);
        bus3.dm_req = 1'b1;
        #1;
        check_val("r3_no_done", 32'(bus3.dm_ready), 32'd0);
        bus3.dm_req = 1'b0;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Arbiter and sequencer that shares one fixed-latency, single-port unified memory between the pipelined datapath's instruction-fetch (IF) and data-memory (DM) stages. It serialises the two requesters and holds each completed result until the pipeline advances. It also drives the memory port.

## Interface
Parameters:
- ADDR_W, 32, address width (byte address, passed through unchanged)
- DATA_W, 32, data width
- MEM_LAT, 2, memory read latency in cycles (legal range 1..15)

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset; synchronous, active-high
- if_req  in  1  fetch request; held high until the pipeline advances
- if_addr  in  ADDR_W  fetch address; stable while if_req is high
- if_ready  out  1  fetch result valid (= if_done & if_req)
- if_rdata  out  DATA_W  fetched instruction; holds its value after capture
- dm_req  in  1  data request; held high until the pipeline advances
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address; stable while dm_req is high
- dm_wdata  in  DATA_W  store data
- dm_ready  out  1  data access complete (= dm_done & dm_req)
- dm_rdata  out  DATA_W  load data
- advance  in  1  pipeline advances this cycle; clears both done flags
- mem_en  out  1  one-cycle issue strobe
- mem_we  out  1  write enable, qualified by mem_en
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  read data, valid MEM_LAT cycles after mem_en
- busy  out  1  state != IDLE

## Operation
- State machine states: IDLE, DM_BUSY, IF_BUSY. The counter cnt is 4 bits wide.
- Pending conditions: IF is pending when if_req & ~if_done. DM is pending when dm_req & ~dm_done.
- Grant: DM has fixed priority over IF, because DM serves the older instruction. There is no starvation: dm_done holds until advance.
- IDLE -> DM_BUSY when DM is pending. Otherwise IDLE -> IF_BUSY when IF is pending.
- On the grant edge the arbiter registers the memory outputs from the winning requester: mem_en=1, mem_we=dm_we (0 for IF), mem_addr, mem_wdata. It also sets cnt=0.
- In BUSY, mem_en=0 after the first cycle. cnt increments each cycle.
- Completion: when cnt==MEM_LAT, the arbiter captures mem_rdata into the granted rdata register and sets the matching done flag. Stores also set dm_done; dm_rdata is left unchanged on a store.
- On the completion edge, the next state is re-evaluated with the same grant rule, using the updated done flags. This allows back-to-back issue with no IDLE bubble.
- advance=1 clears if_done and dm_done on that edge. If advance and completion fall on the same edge, completion wins and the done flag is set.
- Flush: if advance occurs while the state is IF_BUSY, the in-flight fetch is marked discard. At completion, if_rdata is not updated and if_done stays 0. IF is then re-arbitrated using the new if_addr.
- advance while the state is DM_BUSY is a protocol violation. The bench flags it with an assertion. The RTL behaves as in the flush case but does not discard the transaction.
- mem_addr, mem_wdata and mem_we hold their values between issues. Only mem_en is pulsed.

## Timing
- Reset values: state=IDLE, cnt=0, if_done=dm_done=discard=0, mem_en=mem_we=0, mem_addr=mem_wdata=0, if_rdata=dm_rdata=0, if_ready=dm_ready=0, busy=0.
- A request seen in cycle 0 issues mem_en in cycle 1 and sees mem_rdata in cycle 1+MEM_LAT. Ready asserts in cycle 2+MEM_LAT. Single-access latency is MEM_LAT+2.
- When both requests arrive in cycle 0: DM mem_en in cycle 1, dm_ready from cycle MEM_LAT+2, IF mem_en in cycle MEM_LAT+2, if_ready from cycle 2·MEM_LAT+3.
- Readies are registered done flags gated combinationally by req. Dropping req removes ready the same cycle but does not clear the done flag.
- Reset mid-transaction returns the block to IDLE on the next edge. The outstanding memory response is ignored. A store already strobed remains committed in memory.

## Structure
- Package mem_arb_pkg holds:
  - the state enum (IDLE, DM_BUSY, IF_BUSY)
  - the grant encoding (GNT_IF, GNT_DM)
  - the MEM_LAT bounds
- One sub-module, mem_lat_counter: a loadable 4-bit up-counter with a terminal-count compare against MEM_LAT.
- The FSM, grant logic and capture registers live in the top module.

## Test plan
- Single fetch, MEM_LAT=2, if_addr=0x00000004, memory word 0x20020005 -> mem_en in cycle 1 only; if_ready=1 and if_rdata=0x20020005 from cycle 4 until advance.
- Simultaneous requests: load from 0x40 (word 0x0000ABCD) plus fetch from 0x8 -> DM issues first; dm_ready at cycle 4; IF mem_en at cycle 4; if_ready at cycle 7.
- Store: dm_we=1, dm_addr=0x44, dm_wdata=0xDEADBEEF -> mem_en=mem_we=1 for one cycle with matching addr/data; dm_ready at cycle 4; dm_rdata unchanged.
- Flush: advance pulses during IF_BUSY and if_addr changes from 0x10 to 0x30 -> the first result is discarded; a second mem_en issues with addr 0x30; if_rdata equals mem[0x30].
- Advance coincident with completion -> done is still set; the ready asserts on the next cycle.
- rst=1 during DM_BUSY (MEM_LAT=3) -> the next cycle shows busy=0, all readies 0 and mem_en=0; the late mem_rdata is not captured.
